rvlab_rstmgr: RTL and testbench

Reset manager for the FPGA top level. It consumes the clock manager's MMCM lock status, the board reset button and the debug module's non-debug-module reset request, and generates sequenced, synchronous, active-high resets for the peripheral and core domains. It runs on the free-running buffered 100 MHz input clock, so it keeps operating while the gated system clock is stopped. It also counts lock-loss events that occur during normal operation.

---
 rtl/rvlab_rstmgr.sv | 173 +++++++++++++++++
 tb/tb_rvlab_rstmgr.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rvlab_rstmgr.sv
// rvlab_rstmgr: sequenced reset generation for the FPGA top level.
// Runs on the free-running input clock. It synchronizes lock, button and
// ndmreset, debounces the button, sequences the peripheral and core resets,
// and counts lock losses seen while running.
module rvlab_rstmgr #(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 100000,
  parameter int unsigned STRETCH_CYCLES    = 1024,
  parameter int unsigned CORE_DELAY_CYCLES = 16,
  parameter int unsigned CNT_W             = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             locked_i,
  input  logic             btn_rst_ni,
  input  logic             ndm_reset_req_i,
  output logic             rst_periph_o,
  output logic             rst_core_o,
  output logic             rst_done_o,
  output logic [CNT_W-1:0] lock_loss_cnt_o
);

  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SEQ_MAX = (STRETCH_CYCLES > CORE_DELAY_CYCLES) ?
                                    STRETCH_CYCLES : CORE_DELAY_CYCLES;
  localparam int unsigned SEQ_W   = (SEQ_MAX > 2) ? $clog2(SEQ_MAX) : 1;

  // Output decode {rst_periph, rst_core, rst_done} per state
  localparam logic [2:0] DEC_HOLD = 3'b110;
  localparam logic [2:0] DEC_PREL = 3'b010;
  localparam logic [2:0] DEC_RUN  = 3'b001;

  typedef enum logic [1:0] {
    S_HOLD       = 2'd0,
    S_STRETCH    = 2'd1,
    S_PERIPH_REL = 2'd2,
    S_RUN        = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_locked_sync;
  logic [SYNC_STAGES-1:0] r_btn_sync;
  logic [SYNC_STAGES-1:0] r_ndm_sync;
  logic                   w_locked_s;
  logic                   w_btn_s;
  logic                   w_ndm_s;

  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_btn_pressed;
  logic                   w_hard_src;

  state_t                 r_state;
  logic [SEQ_W-1:0]       r_seq_cnt;
  logic                   r_ndm_q;
  logic                   r_rst_periph;
  logic                   r_rst_core;
  logic                   r_rst_done;

  logic                   r_locked_q;
  logic [CNT_W-1:0]       r_loss_cnt;

  assign w_locked_s = r_locked_sync[SYNC_STAGES-1];
  assign w_btn_s    = r_btn_sync[SYNC_STAGES-1];
  assign w_ndm_s    = r_ndm_sync[SYNC_STAGES-1];
  assign w_hard_src = ~w_locked_s | r_btn_pressed;

  // Synchronizer chains for the three asynchronous inputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_locked_sync <= '0;
      r_btn_sync    <= '1;
      r_ndm_sync    <= '0;
    end else begin
      r_locked_sync <= {r_locked_sync[SYNC_STAGES-2:0], locked_i};
      r_btn_sync    <= {r_btn_sync[SYNC_STAGES-2:0], btn_rst_ni};
      r_ndm_sync    <= {r_ndm_sync[SYNC_STAGES-2:0], ndm_reset_req_i};
    end
  end

  // Button debouncer: state flips only after a full run of stable disagreement
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_db_cnt      <= '0;
      r_btn_pressed <= 1'b0;
    end else if (~w_btn_s != r_btn_pressed) begin
      if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_btn_pressed <= ~r_btn_pressed;
        r_db_cnt      <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  // Reset sequencer; outputs are written with the state they decode.
  // Core release credit starts one cycle after the synchronized request is
  // seen low, so a released ndmreset holds the core CORE_DELAY_CYCLES+1 edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state                                 <= S_HOLD;
      r_seq_cnt                               <= '0;
      r_ndm_q                                 <= 1'b0;
      {r_rst_periph, r_rst_core, r_rst_done}  <= DEC_HOLD;
    end else begin
      r_ndm_q <= w_ndm_s;
      if (w_hard_src) begin
        r_state                                <= S_HOLD;
        r_seq_cnt                              <= '0;
        {r_rst_periph, r_rst_core, r_rst_done} <= DEC_HOLD;
      end else begin
        case (r_state)
          S_HOLD: begin
            r_state                                <= S_STRETCH;
            r_seq_cnt                              <= '0;
            {r_rst_periph, r_rst_core, r_rst_done} <= DEC_HOLD;
          end
          S_STRETCH: begin
            if (r_seq_cnt == SEQ_W'(STRETCH_CYCLES - 1)) begin
              r_state                                <= S_PERIPH_REL;
              r_seq_cnt                              <= '0;
              {r_rst_periph, r_rst_core, r_rst_done} <= DEC_PREL;
            end else begin
              r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
            end
          end
          S_PERIPH_REL: begin
            if (w_ndm_s || r_ndm_q) begin
              r_seq_cnt <= '0;
            end else if (r_seq_cnt == SEQ_W'(CORE_DELAY_CYCLES - 1)) begin
              r_state                                <= S_RUN;
              r_seq_cnt                              <= '0;
              {r_rst_periph, r_rst_core, r_rst_done} <= DEC_RUN;
            end else begin
              r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
            end
          end
          S_RUN: begin
            if (w_ndm_s) begin
              r_state                                <= S_PERIPH_REL;
              r_seq_cnt                              <= '0;
              {r_rst_periph, r_rst_core, r_rst_done} <= DEC_PREL;
            end
          end
          default: begin
            r_state                                <= S_HOLD;
            r_seq_cnt                              <= '0;
            {r_rst_periph, r_rst_core, r_rst_done} <= DEC_HOLD;
          end
        endcase
      end
    end
  end

  // Saturating count of lock falling edges observed while running
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_locked_q <= 1'b0;
      r_loss_cnt <= '0;
    end else begin
      r_locked_q <= w_locked_s;
      if ((r_state == S_RUN) && r_locked_q && !w_locked_s && (r_loss_cnt != '1)) begin
        r_loss_cnt <= r_loss_cnt + CNT_W'(1);
      end
    end
  end

  assign rst_periph_o    = r_rst_periph;
  assign rst_core_o      = r_rst_core;
  assign rst_done_o      = r_rst_done;
  assign lock_loss_cnt_o = r_loss_cnt;

endmodule

// File: tb/tb_rvlab_rstmgr.sv
// Scoreboard bench for rvlab_rstmgr: stimulus queues expected output changes
// (edge number and values); a negedge monitor pops one per observed change.
module tb_rvlab_rstmgr;

  localparam int unsigned SYNC_STAGES       = 2;
  localparam int unsigned DEBOUNCE_CYCLES   = 8;
  localparam int unsigned STRETCH_CYCLES    = 16;
  localparam int unsigned CORE_DELAY_CYCLES = 4;
  localparam int unsigned CNT_W             = 2;

  logic             clk_i;
  logic             rst_i;
  logic             locked_i;
  logic             btn_rst_ni;
  logic             ndm_reset_req_i;
  logic             rst_periph_o;
  logic             rst_core_o;
  logic             rst_done_o;
  logic [CNT_W-1:0] lock_loss_cnt_o;

  rvlab_rstmgr #(
    .SYNC_STAGES      (SYNC_STAGES),
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .STRETCH_CYCLES   (STRETCH_CYCLES),
    .CORE_DELAY_CYCLES(CORE_DELAY_CYCLES),
    .CNT_W            (CNT_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .locked_i       (locked_i),
    .btn_rst_ni     (btn_rst_ni),
    .ndm_reset_req_i(ndm_reset_req_i),
    .rst_periph_o   (rst_periph_o),
    .rst_core_o     (rst_core_o),
    .rst_done_o     (rst_done_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  typedef struct {
    int         cyc_exp;
    logic       p;
    logic       c;
    logic       d;
    logic [1:0] n;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_exp;
  int   cyc      = 0;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [4:0] prev_o;
  logic [4:0] cur_o;
  logic [4:0] want_o;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Edge counter: after the k-th rising edge, cyc == k
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic go_to(input int n);
    while (cyc < n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic expect_evt(input int e, input logic p, input logic c, input logic d,
                            input logic [1:0] n);
    exp_t x;
    x.cyc_exp = e;
    x.p = p;
    x.c = c;
    x.d = d;
    x.n = n;
    sb_q.push_back(x);
  endtask

  // Monitor: every change of the outputs (plus the first sample) is a DUT event
  always @(negedge clk_i) begin
    if (cyc >= 1) begin
      cur_o = {rst_periph_o, rst_core_o, rst_done_o, lock_loss_cnt_o};
      if (cyc == 1 || cur_o != prev_o) begin
        if (sb_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_change edge=%0d got p/c/d/cnt=%b", cyc, cur_o);
        end else begin
          m_exp  = sb_q.pop_front();
          want_o = {m_exp.p, m_exp.c, m_exp.d, m_exp.n};
          n_assert += 2;
          if (m_exp.cyc_exp != cyc) begin
            n_fail++;
            $display("FAIL event_timing got edge=%0d required edge=%0d (values %b)",
                     cyc, m_exp.cyc_exp, want_o);
          end
          if (cur_o != want_o) begin
            n_fail++;
            $display("FAIL event_value edge=%0d got p/c/d/cnt=%b required=%b",
                     cyc, cur_o, want_o);
          end
        end
      end
      prev_o = cur_o;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int s;
    logic [1:0] nexp;
    rst_i           = 1'b1;
    locked_i        = 1'b0;
    btn_rst_ni      = 1'b1;
    ndm_reset_req_i = 1'b0;

    // Power-up: reset values, then the full release sequence
    expect_evt(1, 1'b1, 1'b1, 1'b0, 2'd0);
    go_to(3);
    rst_i = 1'b0;
    go_to(10);
    locked_i = 1'b1;
    expect_evt(29, 1'b0, 1'b1, 1'b0, 2'd0);
    expect_evt(33, 1'b0, 1'b0, 1'b1, 2'd0);

    // Four lock losses from RUN; the counter saturates at 3
    for (int k = 1; k <= 4; k++) begin
      b    = 40 + 35 * (k - 1);
      nexp = (k > 3) ? 2'd3 : 2'(k);
      go_to(b);
      locked_i = 1'b0;
      expect_evt(b + 3, 1'b1, 1'b1, 1'b0, nexp);
      go_to(b + 5);
      locked_i = 1'b1;
      expect_evt(b + 24, 1'b0, 1'b1, 1'b0, nexp);
      expect_evt(b + 28, 1'b0, 1'b0, 1'b1, nexp);
    end

    // ndmreset for 10 cycles: only the core reset pulses
    b = 180;
    go_to(b);
    ndm_reset_req_i = 1'b1;
    expect_evt(b + 3, 1'b0, 1'b1, 1'b0, 2'd3);
    go_to(b + 10);
    ndm_reset_req_i = 1'b0;
    expect_evt(b + 17, 1'b0, 1'b0, 1'b1, 2'd3);

    // Button bounce: three 5-cycle pulses are filtered, sustained press is not
    b = 205;
    for (int i = 0; i < 3; i++) begin
      go_to(b + 10 * i);
      btn_rst_ni = 1'b0;
      go_to(b + 10 * i + 5);
      btn_rst_ni = 1'b1;
    end
    s = 235;
    go_to(s);
    btn_rst_ni = 1'b0;
    expect_evt(s + 11, 1'b1, 1'b1, 1'b0, 2'd3);
    go_to(s + 20);
    btn_rst_ni = 1'b1;
    expect_evt(s + 47, 1'b0, 1'b1, 1'b0, 2'd3);
    expect_evt(s + 51, 1'b0, 1'b0, 1'b1, 2'd3);

    // Simultaneous ndm request and lock loss: hard reset wins
    b = 295;
    go_to(b);
    locked_i        = 1'b0;
    ndm_reset_req_i = 1'b1;
    expect_evt(b + 3, 1'b1, 1'b1, 1'b0, 2'd3);
    go_to(b + 5);
    locked_i        = 1'b1;
    ndm_reset_req_i = 1'b0;
    expect_evt(b + 24, 1'b0, 1'b1, 1'b0, 2'd3);
    // rst_i while in PERIPH_REL: everything back to reset values
    go_to(b + 26);
    rst_i = 1'b1;
    expect_evt(b + 27, 1'b1, 1'b1, 1'b0, 2'd0);
    go_to(b + 28);
    rst_i = 1'b0;
    expect_evt(b + 47, 1'b0, 1'b1, 1'b0, 2'd0);
    expect_evt(b + 51, 1'b0, 1'b0, 1'b1, 2'd0);

    // Fresh power-up with a 3-cycle lock glitch during STRETCH
    b = 355;
    go_to(b);
    rst_i    = 1'b1;
    locked_i = 1'b0;
    expect_evt(b + 1, 1'b1, 1'b1, 1'b0, 2'd0);
    go_to(b + 3);
    rst_i = 1'b0;
    go_to(b + 10);
    locked_i = 1'b1;
    go_to(b + 20);
    locked_i = 1'b0;
    go_to(b + 23);
    locked_i = 1'b1;
    expect_evt(b + 42, 1'b0, 1'b1, 1'b0, 2'd0);
    expect_evt(b + 46, 1'b0, 1'b0, 1'b1, 2'd0);

    go_to(420);
    n_assert++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events got %0d left, required 0 (next at edge %0d)",
               sb_q.size(), sb_q[0].cyc_exp);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
